// File: rtl/sink_arbiter_pkg.sv
// rtl/sink_arbiter_pkg.sv - shared constants and index helpers for the sink arbiter
package sink_arbiter_pkg;

  // Width of the consecutive-grant counter; bounds BURST at 255.
  localparam int RUN_W     = 8;
  localparam int MAX_PORTS = 16;
  localparam int MAX_BURST = (1 << RUN_W) - 1;

  // Round-robin step that wraps at the real port count, not at 2**PTR_W,
  // so unused index codes are never produced.
  function automatic int wrap_add(input int base, input int step, input int ports);
    int s;
    s = base + step;
    if (s >= ports) s = s - ports;
    return s;
  endfunction

endpackage

// File: rtl/sink_arbiter_rr_pick.sv
// rtl/sink_arbiter_rr_pick.sv - combinational round-robin winner select with burst lock
module sink_arbiter_rr_pick
  import sink_arbiter_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int PTR_W = 2
) (
  input  logic [PORTS-1:0] req_i,
  input  logic [PTR_W-1:0] start_i,
  input  logic             lock_en_i,
  input  logic [PTR_W-1:0] lock_idx_i,
  output logic [PTR_W-1:0] win_o,
  output logic             found_o
);

  logic [PTR_W-1:0] cand;

  // Locked source keeps the grant while it still requests; otherwise scan
  // start+1 .. start (inclusive) and take the first requester.
  always_comb begin
    win_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    if (lock_en_i && req_i[lock_idx_i]) begin
      win_o   = lock_idx_i;
      found_o = 1'b1;
    end else begin
      for (int k = 1; k <= PORTS; k++) begin
        cand = PTR_W'(wrap_add(int'(start_i), k, PORTS));
        if (!found_o && req_i[cand]) begin
          win_o   = cand;
          found_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sink_arbiter.sv
// rtl/sink_arbiter.sv - round-robin merge of several req/busy sources into one registered sink
`ifndef SIZE
`define SIZE 8
`endif

module sink_arbiter
  import sink_arbiter_pkg::*;
#(
  parameter int id    = -1,
  parameter int PORTS = 4,
  parameter int PTR_W = 2,
  parameter int BURST = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PORTS-1:0]        req_in,
  input  logic [PORTS*`SIZE-1:0]  data_in,
  output logic [PORTS-1:0]        busy_out,
  output logic                    req_out,
  output logic [`SIZE-1:0]        data_out,
  input  logic                    busy_in
);

  // Reject parameter sets the index arithmetic cannot support.
  if (PORTS < 2 || PORTS > MAX_PORTS) begin : g_bad_ports
    $error("sink_arbiter: PORTS out of range");
  end
  if ((1 << PTR_W) < PORTS) begin : g_bad_ptr
    $error("sink_arbiter: PTR_W too narrow for PORTS");
  end
  if (BURST < 1 || BURST > MAX_BURST) begin : g_bad_burst
    $error("sink_arbiter: BURST out of range");
  end
  if (id < -1) begin : g_bad_id
    $error("sink_arbiter: id must be -1 or a non-negative instance number");
  end

  logic             req_q,  req_d;
  logic [`SIZE-1:0] data_q, data_d;
  logic [PTR_W-1:0] last_q, last_d;
  logic [RUN_W-1:0] run_q,  run_d;

  logic             accept_en;
  logic             accept;
  logic             lock_en;
  logic [PTR_W-1:0] win;
  logic             found;

  assign accept_en = !reset && (!req_q || !busy_in);
  assign lock_en   = (run_q != '0) && (run_q < RUN_W'(BURST));
  assign accept    = accept_en && found;

  sink_arbiter_rr_pick #(
    .PORTS (PORTS),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i      (req_in),
    .start_i    (last_q),
    .lock_en_i  (lock_en),
    .lock_idx_i (last_q),
    .win_o      (win),
    .found_o    (found)
  );

  // Only the source being accepted this cycle sees busy low; reset holds all busy.
  always_comb begin
    busy_out = '1;
    if (accept) busy_out[win] = 1'b0;
  end

  // Next state: accept overwrites the stage (also covers drain+accept), drain alone empties it.
  always_comb begin
    req_d  = req_q;
    data_d = data_q;
    last_d = last_q;
    run_d  = run_q;
    if (accept) begin
      req_d  = 1'b1;
      data_d = data_in[int'(win)*`SIZE +: `SIZE];
      last_d = win;
      if (win == last_q && run_q < RUN_W'(BURST)) run_d = run_q + RUN_W'(1);
      else                                       run_d = RUN_W'(1);
    end else if (req_q && !busy_in) begin
      req_d = 1'b0;
    end
  end

  // State register; reset discards any held word and restarts priority at port 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q  <= 1'b0;
      data_q <= '0;
      last_q <= PTR_W'(PORTS - 1);
      run_q  <= '0;
    end else begin
      req_q  <= req_d;
      data_q <= data_d;
      last_q <= last_d;
      run_q  <= run_d;
    end
  end

  assign req_out  = req_q;
  assign data_out = data_q;

endmodule

// File: tb/tb_sink_arbiter.sv
// tb/tb_sink_arbiter.sv - scoreboard bench for sink_arbiter with BURST=1 and BURST=2 instances
`ifndef SIZE
`define SIZE 8
`endif

module tb_sink_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_in_a   [2];
  logic [31:0] data_in_a  [2];
  logic [3:0]  busy_out_a [2];
  logic        req_out_a  [2];
  logic [7:0]  data_out_a [2];
  logic        busy_in_a  [2];

  logic [7:0]  nxt [2][4];
  logic [7:0]  exp_q0[$];
  logic [7:0]  exp_q1[$];

  int n_checks = 0;
  int n_pass   = 0;

  sink_arbiter #(.id(-1), .PORTS(4), .PTR_W(2), .BURST(1)) u_dut0 (
    .clk(clk), .reset(reset), .req_in(req_in_a[0]), .data_in(data_in_a[0]),
    .busy_out(busy_out_a[0]), .req_out(req_out_a[0]), .data_out(data_out_a[0]),
    .busy_in(busy_in_a[0])
  );

  sink_arbiter #(.id(-1), .PORTS(4), .PTR_W(2), .BURST(2)) u_dut1 (
    .clk(clk), .reset(reset), .req_in(req_in_a[1]), .data_in(data_in_a[1]),
    .busy_out(busy_out_a[1]), .req_out(req_out_a[1]), .data_out(data_out_a[1]),
    .busy_in(busy_in_a[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic refresh();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 4; p++)
        data_in_a[d][p*8 +: 8] = nxt[d][p];
  endtask

  // Port p emits p*16, p*16+1, ... so every word names its source.
  task automatic seed();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 4; p++)
        nxt[d][p] = 8'(p * 16);
    refresh();
  endtask

  task automatic push_exp(input int d, input logic [7:0] w);
    if (d == 0) exp_q0.push_back(w);
    else        exp_q1.push_back(w);
  endtask

  // One clock: sample handshakes at negedge, advance sources just after posedge.
  task automatic tick();
    logic [3:0] xf [2];
    @(negedge clk);
    for (int d = 0; d < 2; d++) xf[d] = req_in_a[d] & ~busy_out_a[d];
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 4; p++)
        if (xf[d][p]) nxt[d][p] = nxt[d][p] + 8'd1;
    refresh();
  endtask

  task automatic reset_cycle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    seed();
  endtask

  // Scoreboard: every word leaving the output stage must be the next expected one.
  always @(negedge clk) begin
    logic [7:0] e;
    int sz;
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        if (req_out_a[d] && !busy_in_a[d]) begin
          sz = (d == 0) ? exp_q0.size() : exp_q1.size();
          if (sz == 0) begin
            chk($sformatf("unexpected_word_dut%0d", d), 32'(sz), 32'd1);
          end else begin
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk($sformatf("out_dut%0d", d), 32'(data_out_a[d]), 32'(e));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_in_a[d]  = 4'h0;
      busy_in_a[d] = 1'b0;
    end
    seed();

    // Reset with every source requesting, then BURST=1 rotation.
    req_in_a[0] = 4'hF;
    repeat (3) begin
      tick();
      chk("rst_busy", 32'(busy_out_a[0]), 32'hF);
      chk("rst_req_out", 32'(req_out_a[0]), 32'd0);
    end
    reset = 1'b0;
    #1;
    chk("first_grant_p0", 32'(busy_out_a[0]), 32'b1110);
    push_exp(0, 8'h00); push_exp(0, 8'h10); push_exp(0, 8'h20);
    push_exp(0, 8'h30); push_exp(0, 8'h01); push_exp(0, 8'h11);
    repeat (6) tick();
    req_in_a[0] = 4'h0;
    repeat (3) tick();
    chk("rr_drained", 32'(exp_q0.size()), 32'd0);

    // Single continuous requester is re-granted every cycle.
    reset_cycle();
    nxt[0][2] = 8'd10;
    refresh();
    req_in_a[0] = 4'b0100;
    push_exp(0, 8'd10); push_exp(0, 8'd11); push_exp(0, 8'd12);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("single_busy2", 32'(busy_out_a[0][2]), 32'd0);
      tick();
      chk("single_req_out", 32'(req_out_a[0]), 32'd1);
      chk("single_data", 32'(data_out_a[0]), 32'(10 + k));
    end
    req_in_a[0] = 4'h0;
    repeat (2) tick();
    chk("single_drained", 32'(exp_q0.size()), 32'd0);

    // BURST=2 with ports 1 and 3 competing.
    reset_cycle();
    push_exp(1, 8'h10); push_exp(1, 8'h11); push_exp(1, 8'h30);
    push_exp(1, 8'h31); push_exp(1, 8'h12); push_exp(1, 8'h13);
    req_in_a[1] = 4'b1010;
    repeat (6) tick();
    req_in_a[1] = 4'h0;
    repeat (3) tick();
    chk("burst_drained", 32'(exp_q1.size()), 32'd0);

    // BURST=2 with port 3 dropping after one grant.
    reset_cycle();
    push_exp(1, 8'h10); push_exp(1, 8'h11); push_exp(1, 8'h30);
    push_exp(1, 8'h12); push_exp(1, 8'h13);
    for (int k = 0; k < 5; k++) begin
      req_in_a[1] = (k < 3) ? 4'b1010 : 4'b0010;
      tick();
    end
    req_in_a[1] = 4'h0;
    repeat (3) tick();
    chk("burst_drop_drained", 32'(exp_q1.size()), 32'd0);

    // Backpressure: held word frozen, then drain and accept on the same edge.
    reset_cycle();
    push_exp(1, 8'h00); push_exp(1, 8'h10);
    req_in_a[1] = 4'b0001;
    tick();
    req_in_a[1]  = 4'b0010;
    busy_in_a[1] = 1'b1;
    repeat (4) begin
      #1;
      chk("hold_busy", 32'(busy_out_a[1]), 32'hF);
      chk("hold_data", 32'(data_out_a[1]), 32'h00);
      chk("hold_req_out", 32'(req_out_a[1]), 32'd1);
      tick();
    end
    busy_in_a[1] = 1'b0;
    #1;
    chk("no_bubble_busy", 32'(busy_out_a[1]), 32'b1101);
    tick();
    chk("no_bubble_data", 32'(data_out_a[1]), 32'h10);
    chk("no_bubble_req_out", 32'(req_out_a[1]), 32'd1);
    req_in_a[1] = 4'h0;
    repeat (2) tick();
    chk("hold_drained", 32'(exp_q1.size()), 32'd0);

    // Reset mid-stream discards the held word; port 0 wins first afterwards.
    reset_cycle();
    push_exp(0, 8'h10);
    req_in_a[0] = 4'b0110;
    tick();
    tick();
    chk("mid_req_out_before", 32'(req_out_a[0]), 32'd1);
    reset = 1'b1;
    tick();
    chk("mid_req_out_cleared", 32'(req_out_a[0]), 32'd0);
    chk("mid_busy_in_reset", 32'(busy_out_a[0]), 32'hF);
    reset = 1'b0;
    req_in_a[0] = 4'b0111;
    #1;
    chk("mid_first_grant_p0", 32'(busy_out_a[0]), 32'b1110);
    push_exp(0, 8'h00); push_exp(0, 8'h11); push_exp(0, 8'h21);
    repeat (3) tick();
    req_in_a[0] = 4'h0;
    repeat (2) tick();
    chk("mid_drained", 32'(exp_q0.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
